// File: rtl/aes_spi_master_if.sv
// Host request/result and SPI-plus-handshake signals of the AES SPI initiator.
// master is the initiator's view; slave is the host/responder view.
`timescale 1ns/1ps
interface aes_spi_master_if;
  logic         start;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         busy;
  logic         valid;
  logic [127:0] cyphertext;
  logic         error;
  logic         sck;
  logic         sdi;
  logic         sdo;
  logic         load;
  logic         done;

  modport master (
    input  start, key, plaintext, sdo, done,
    output busy, valid, cyphertext, error, sck, sdi, load
  );

  modport slave (
    output start, key, plaintext, sdo, done,
    input  busy, valid, cyphertext, error, sck, sdi, load
  );
endinterface

// File: rtl/aes_spi_master.sv
// SPI initiator for the AES core: shifts {plaintext, key} out under load, waits for done and
// shifts the 128-bit result back. Optional WAIT_DONE timeout: define AES_SPI_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
module aes_spi_master #(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             nreset,
  aes_spi_master_if.master bus
);

  localparam int unsigned      DivW    = $clog2(CLK_DIV + 1);
  localparam logic [DivW-1:0]  DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StShiftIn, StRelease, StWaitDone, StShiftOut
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [8:0]      bit_q, bit_d;
  logic [255:0]    tx_q, tx_d;
  logic [126:0]    rx_q, rx_d;
  logic [127:0]    ct_q, ct_d;
  logic            sck_q, sck_d;
  logic            load_q, load_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            done_meta_q, done_s_q;
  logic            half_end, sck_fall, timeout;

  assign half_end = (div_q == DivLast);
  assign sck_fall = sck_q & half_end;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      done_meta_q <= 1'b0;
      done_s_q    <= 1'b0;
    end else begin
      done_meta_q <= bus.done;
      done_s_q    <= done_meta_q;
    end
  end

`ifdef AES_SPI_MASTER_TIMEOUT_EN
  localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_q;
  logic            err_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == StWaitDone) ? tmo_q + 1'b1 : '0;
      if (state_q == StIdle && bus.start) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign timeout   = (state_q == StWaitDone) && !done_s_q && (tmo_q == TmoLast);
  assign bus.error = err_q;
`else
  assign timeout   = 1'b0;
  assign bus.error = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (bus.start) state_d = StSetup;
      StSetup:    if (half_end) state_d = StShiftIn;
      StShiftIn:  if (sck_fall && bit_q == 9'd255) state_d = StRelease;
      StRelease:  if (half_end) state_d = StWaitDone;
      StWaitDone: begin
        if (done_s_q) begin
          state_d = StShiftOut;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StShiftOut: if (sck_fall && bit_q == 9'd127) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    ct_d    = ct_q;
    sck_d   = sck_q;
    load_d  = load_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          tx_d   = {bus.plaintext, bus.key};
          load_d = 1'b1;
          busy_d = 1'b1;
          div_d  = '0;
          bit_d  = '0;
        end
      end
      StSetup, StRelease: begin
        div_d = half_end ? '0 : div_q + 1'b1;
        if (state_q == StSetup && half_end) sck_d = 1'b1;
      end
      StShiftIn, StShiftOut: begin
        div_d = half_end ? '0 : div_q + 1'b1;
        if (half_end) sck_d = ~sck_q;
        // The sdo sample shares the edge that ends the high phase, i.e. the falling transition.
        if (sck_fall) begin
          bit_d = bit_q + 9'd1;
          if (state_q == StShiftIn) begin
            tx_d = {tx_q[254:0], 1'b0};
            if (bit_q == 9'd255) begin
              load_d = 1'b0;
              bit_d  = '0;
            end
          end else begin
            rx_d = {rx_q[125:0], bus.sdo};
            if (bit_q == 9'd127) begin
              ct_d    = {rx_q, bus.sdo};
              valid_d = 1'b1;
              busy_d  = 1'b0;
              bit_d   = '0;
            end
          end
        end
      end
      StWaitDone: begin
        div_d = '0;
        if (done_s_q) begin
          sck_d = 1'b1;
        end else if (timeout) begin
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      ct_q    <= '0;
      sck_q   <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      ct_q    <= ct_d;
      sck_q   <= sck_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  // sdi is the shift register MSB; it only moves on falling sck edges and drains to 0.
  assign bus.sdi        = tx_q[255];
  assign bus.sck        = sck_q;
  assign bus.load       = load_q;
  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.cyphertext = ct_q;

endmodule
